memp_writer: RTL and testbench
==============================

MEMP_WRITER -- requirements
Module: memp_writer

Interface
REQ-001 The block SHALL have parameter number_of_clusters, default 1, meaning the number of wide rows written per pass.
REQ-002 The block SHALL have parameter number_of_equations_per_cluster, default 9, meaning the number of elements packed per row (N).
REQ-003 The block SHALL have parameter element_width, default 64, meaning the bits per element (W).
REQ-004 The block SHALL have parameter address_width, default 20, meaning the write address width.
REQ-005 The block SHALL have port clk  input  1  system clock, with all logic on its rising edge.
REQ-006 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 The block SHALL have port start  input  1  single-cycle request to begin a pass.
REQ-008 The block SHALL have port in_valid  input  1  element-stream valid.
REQ-009 The block SHALL have port in_data  input  W  element-stream data.
REQ-010 The block SHALL have port in_ready  output  1  element-stream ready.
REQ-011 The block SHALL have port write_enable  output  1  row write strobe to the P memory.
REQ-012 The block SHALL have port mem_write_address  output  address_width  row address for the P memory.
REQ-013 The block SHALL have port mem_write_data  output  N*W  packed row for the P memory.
REQ-014 The block SHALL have port busy  output  1  high in FILL or WRITE.
REQ-015 The block SHALL have port finish  output  1  level, high in DONE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FILL, WRITE and DONE.
REQ-017 In IDLE, in_ready SHALL be 0, and start SHALL cause a transition to FILL with the element count and row address cleared to 0.
REQ-018 In FILL, in_ready SHALL be 1, and each cycle with in_valid=1 and in_ready=1 SHALL accept one element.
REQ-019 Element k of a row (k=0..N-1) SHALL occupy mem_write_data bits [k*W+W-1 : k*W], so element 0 is at the LSB.
REQ-020 When element N-1 of a row is accepted, the FSM SHALL move to WRITE on that edge.
REQ-021 In WRITE, write_enable SHALL be 1 for exactly one cycle, with mem_write_address equal to the row address and mem_write_data equal to the full packed row, and in_ready SHALL be 0.
REQ-022 Latency: if the last element is accepted at edge t, write_enable SHALL be high from edge t to edge t+1, and the memory captures the row at edge t+1.
REQ-023 After WRITE, if the row address equals number_of_clusters-1 the FSM SHALL go to DONE; otherwise the row address SHALL increment and the FSM SHALL go to FILL.
REQ-024 The row address SHALL never exceed number_of_clusters-1, with no wrap-around within a pass.
REQ-025 In DONE, finish SHALL be 1 and in_ready SHALL be 0, and start SHALL clear finish, clear both counters and go to FILL.
REQ-026 start SHALL be ignored in FILL and WRITE.
REQ-027 When start and in_valid are both high in IDLE or DONE, no element SHALL be accepted in that cycle.
REQ-028 When N=1, every accepted element SHALL produce a WRITE cycle directly.
REQ-029 When number_of_clusters=1, a single WRITE SHALL lead to DONE.
REQ-030 write_enable SHALL be 0 in every state other than WRITE.
REQ-031 mem_write_data and mem_write_address SHALL hold their values outside WRITE.

Reset
REQ-032 While reset_n=0 at a rising edge, the block SHALL enter IDLE with write_enable=0, in_ready=0, busy=0, finish=0, mem_write_address=0, mem_write_data=0 and both counters at 0.
REQ-033 A reset during FILL or WRITE SHALL discard the partial row and SHALL NOT produce any write after the reset edge.

Structure
REQ-034 The state encoding (IDLE, FILL, WRITE, DONE) and the default parameter constants SHALL be defined in shared package memp_pkg.
REQ-035 The row packing SHALL be a single sub-module, memp_row_packer, holding the element counter, the slice-write register and a row_full indication; the FSM and address counter SHALL stay in memp_writer.

Verification (bench parameters: N=9, W=64, number_of_clusters=2)
REQ-036 Basic pass: start, then 18 back-to-back elements with values 1..18 SHALL give write_enable at address 0 with data {9,...,1} (element 1 at the LSB), then at address 1 with data {18,...,10}, then finish=1.
REQ-037 Backpressure gaps: in_valid toggling 1,0,1,0 per cycle SHALL produce the same two rows as the basic pass, with each write_enable pulse exactly one cycle wide.
REQ-038 Reset mid-row: reset_n=0 after 5 accepted elements SHALL give no write, all outputs 0, and a following start with 18 elements SHALL yield correct rows at addresses 0 and 1.
REQ-039 Start while busy: start pulsed during FILL at element 4 SHALL leave the counters unchanged and produce the correct rows.
REQ-040 Restart from DONE: start in DONE SHALL set finish=0 on the next cycle, and new values 100..117 SHALL overwrite rows 0 and 1.
REQ-041 Start with valid in IDLE: start=1 together with in_valid=1 and in_data=0xAA SHALL not accept 0xAA, and the first accepted element SHALL be the one presented in the next cycle.

Source files
------------

// File: rtl/memp_pkg.sv
// Shared state encoding and default sizing for the P-memory row writer.
package memp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } memp_state_e;

  localparam int unsigned DEF_NUMBER_OF_CLUSTERS              = 1;
  localparam int unsigned DEF_NUMBER_OF_EQUATIONS_PER_CLUSTER = 9;
  localparam int unsigned DEF_ELEMENT_WIDTH                   = 64;
  localparam int unsigned DEF_ADDRESS_WIDTH                   = 20;

  // Counter width that stays legal when only one element per row is packed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memp_row_packer.sv
// Packs a stream of W-bit elements into an N*W row, element 0 at the LSB.
// row_full flags the accept of the last element; row_next already contains it.
module memp_row_packer
  import memp_pkg::*;
#(
  parameter int unsigned n_elems    = DEF_NUMBER_OF_EQUATIONS_PER_CLUSTER,
  parameter int unsigned elem_width = DEF_ELEMENT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            accept,
  input  logic [elem_width-1:0]           elem_data,
  output logic [n_elems*elem_width-1:0]   row_next,
  output logic                            row_full
);

  localparam int unsigned CW = cnt_width(n_elems);
  localparam int unsigned RW = n_elems * elem_width;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_slot;

  assign last_slot = (cnt_q == CW'(n_elems - 1));

  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      row_d[int'(cnt_q)*elem_width +: elem_width] = elem_data;
      cnt_d = last_slot ? '0 : cnt_q + 1'b1;
    end
  end

  assign row_next = row_d;
  assign row_full = accept && !clear && last_slot;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/memp_writer.sv
// Collects N elements per row and writes number_of_clusters rows into the P memory.
// write_enable rises on the edge that accepts a row's last element; in_ready drops for that WRITE cycle.
module memp_writer
  import memp_pkg::*;
#(
  parameter int unsigned number_of_clusters              = DEF_NUMBER_OF_CLUSTERS,
  parameter int unsigned number_of_equations_per_cluster = DEF_NUMBER_OF_EQUATIONS_PER_CLUSTER,
  parameter int unsigned element_width                   = DEF_ELEMENT_WIDTH,
  parameter int unsigned address_width                   = DEF_ADDRESS_WIDTH
) (
  input  logic                                                      clk,
  input  logic                                                      reset_n,
  input  logic                                                      start,
  input  logic                                                      in_valid,
  input  logic [element_width-1:0]                                  in_data,
  output logic                                                      in_ready,
  output logic                                                      write_enable,
  output logic [address_width-1:0]                                  mem_write_address,
  output logic [number_of_equations_per_cluster*element_width-1:0]  mem_write_data,
  output logic                                                      busy,
  output logic                                                      finish
);

  localparam int unsigned RW = number_of_equations_per_cluster * element_width;

  memp_state_e              state_q, state_d;
  logic [address_width-1:0] row_addr_q, row_addr_d;
  logic [address_width-1:0] wr_addr_q, wr_addr_d;
  logic [RW-1:0]            wr_data_q, wr_data_d;
  logic                     in_ready_q, in_ready_d;
  logic                     write_enable_q, write_enable_d;
  logic                     busy_q, busy_d;
  logic                     finish_q, finish_d;
  logic                     accept, clear;
  logic [RW-1:0]            row_next;
  logic                     row_full;

  // in_ready is a flop that is only high in FILL, so start never collides with an accept.
  assign accept = in_ready_q && in_valid;

  memp_row_packer #(
    .n_elems    (number_of_equations_per_cluster),
    .elem_width (element_width)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .accept    (accept),
    .elem_data (in_data),
    .row_next  (row_next),
    .row_full  (row_full)
  );

  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clear      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FILL;
          row_addr_d = '0;
          clear      = 1'b1;
        end
      end
      FILL: begin
        if (row_full) begin
          state_d   = WRITE;
          wr_addr_d = row_addr_q;
          wr_data_d = row_next;
        end
      end
      WRITE: begin
        if (row_addr_q == address_width'(number_of_clusters - 1)) begin
          state_d = DONE;
        end else begin
          row_addr_d = row_addr_q + 1'b1;
          state_d    = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d     = (state_d == FILL);
    write_enable_d = (state_d == WRITE);
    busy_d         = (state_d == FILL) || (state_d == WRITE);
    finish_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      row_addr_q     <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      in_ready_q     <= 1'b0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      finish_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_addr_q     <= row_addr_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      in_ready_q     <= in_ready_d;
      write_enable_q <= write_enable_d;
      busy_q         <= busy_d;
      finish_q       <= finish_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign write_enable      = write_enable_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign busy              = busy_q;
  assign finish            = finish_q;

endmodule

// File: tb/tb_memp_writer.sv
// Randomized self-checking bench for memp_writer with N=9, W=64, two rows per pass.
module tb_memp_writer;

  localparam int N  = 9;
  localparam int W  = 64;
  localparam int NC = 2;
  localparam int AW = 20;
  localparam int RW = N * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          write_enable;
  logic [AW-1:0] mem_write_address;
  logic [RW-1:0] mem_write_data;
  logic          busy;
  logic          finish;

  int checks   = 0;
  int failures = 0;

  // Every write seen on the memory port, as {address, row}.
  logic [AW+RW-1:0] wq[$];
  int run_len = 0;
  int max_run = 0;

  memp_writer #(
    .number_of_clusters              (NC),
    .number_of_equations_per_cluster (N),
    .element_width                   (W),
    .address_width                   (AW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .write_enable      (write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .busy              (busy),
    .finish            (finish)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wq.push_back({mem_write_address, mem_write_data});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // Reference: row r holds elements r*N .. r*N+N-1 of the pass, first one at the LSB.
  function automatic logic [RW-1:0] pack_row(input logic [W-1:0] vals[$], input int r);
    logic [RW-1:0] row;
    row = '0;
    for (int k = 0; k < N; k++) row[k*W +: W] = vals[r*N + k];
    return row;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents each value until taken; gap_mode 0 none, 1 one idle cycle, 2 random 0..2 idle cycles.
  task automatic drive(input logic [W-1:0] vals[$], input int gap_mode, input int start_at,
                       output bit ok);
    ok = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      int guard;
      int gaps;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = vals[i];
      start    = (i == start_at);
      @(negedge clk);
      while (!in_ready && guard < 20) begin
        @(posedge clk); #1;
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      if (guard >= 20) begin
        ok = 1'b0;
        return;
      end
      gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (gaps) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_finish(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (finish === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({write_enable, in_ready, busy, finish} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000", {write_enable, in_ready, busy, finish});
    end
    checks++;
    if (mem_write_address !== '0 || mem_write_data !== '0) begin
      failures++;
      $display("FAIL reset_mem_port addr=%h data=%h required zero", mem_write_address, mem_write_data);
    end
    @(posedge clk); #1;
    reset_n  = 1'b1;
    wq.delete();
    in_valid = 1'b1;
    in_data  = 64'h55;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || wq.size() != 0) begin
      failures++;
      $display("FAIL idle_no_accept in_ready=%b busy=%b writes=%0d required 0 0 0",
               in_ready, busy, wq.size());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] lo[$], hi[$], vals[$];
    bit ok1, ok2, seen;
    for (int i = 1; i <= 2*N; i++) begin
      vals.push_back(W'(i));
      if (i <= N) lo.push_back(W'(i)); else hi.push_back(W'(i));
    end
    wq.delete(); max_run = 0;
    do_start();
    drive(lo, 0, -1, ok1);
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b1 || mem_write_address !== AW'(0)) begin
      failures++;
      $display("FAIL basic_latency we=%b addr=%0d required we=1 addr=0", write_enable, mem_write_address);
    end
    @(posedge clk); #1;
    drive(hi, 0, -1, ok2);
    wait_finish(seen);
    checks++;
    if (!(ok1 && ok2) || !seen || wq.size() != NC) begin
      failures++;
      $display("FAIL basic_flow accepted=%b finish=%b writes=%0d required 1 1 %0d",
               ok1 && ok2, seen, wq.size(), NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL basic_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] vals[$];
    bit ok, seen;
    for (int i = 1; i <= 2*N; i++) vals.push_back(W'(i));
    wq.delete(); max_run = 0;
    do_start();
    drive(vals, 1, -1, ok);
    wait_finish(seen);
    checks++;
    if (!ok || !seen || wq.size() != NC || max_run != 1) begin
      failures++;
      $display("FAIL gaps_flow accepted=%b finish=%b writes=%0d pulse=%0d required 1 1 %0d 1",
               ok, seen, wq.size(), max_run, NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL gaps_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [W-1:0] vals[$];
    bit ok, seen;
    for (int i = 0; i < 2*N; i++) vals.push_back({$urandom, $urandom});
    wq.delete(); max_run = 0;
    do_start();
    drive(vals, 0, 4, ok);
    wait_finish(seen);
    checks++;
    if (!ok || !seen || wq.size() != NC) begin
      failures++;
      $display("FAIL start_busy_flow accepted=%b finish=%b writes=%0d required 1 1 %0d",
               ok, seen, wq.size(), NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL start_busy_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] vals[$];
    bit ok, seen;
    for (int i = 100; i < 100 + 2*N; i++) vals.push_back(W'(i));
    wq.delete(); max_run = 0;
    do_start();
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear finish=%b busy=%b required finish=0 busy=1", finish, busy);
    end
    @(posedge clk); #1;
    drive(vals, 0, -1, ok);
    wait_finish(seen);
    checks++;
    if (!ok || !seen || wq.size() != NC) begin
      failures++;
      $display("FAIL restart_flow accepted=%b finish=%b writes=%0d required 1 1 %0d",
               ok, seen, wq.size(), NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL restart_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    logic [W-1:0] part[$], vals[$];
    bit ok, seen;
    for (int i = 0; i < 5; i++) part.push_back({$urandom, $urandom});
    for (int i = 0; i < 2*N; i++) vals.push_back({$urandom, $urandom});
    wq.delete(); max_run = 0;
    do_start();
    drive(part, 0, -1, ok);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({write_enable, in_ready, busy, finish} !== 4'b0000 ||
        mem_write_address !== '0 || mem_write_data !== '0) begin
      failures++;
      $display("FAIL midrow_reset_outputs flags=%b addr=%h data=%h required all zero",
               {write_enable, in_ready, busy, finish}, mem_write_address, mem_write_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (!ok || wq.size() != 0) begin
      failures++;
      $display("FAIL midrow_no_write accepted=%b writes=%0d required 1 0", ok, wq.size());
    end
    do_start();
    drive(vals, 0, -1, ok);
    wait_finish(seen);
    checks++;
    if (!ok || !seen || wq.size() != NC) begin
      failures++;
      $display("FAIL midrow_flow accepted=%b finish=%b writes=%0d required 1 1 %0d",
               ok, seen, wq.size(), NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL midrow_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_start_valid_idle();
    logic [W-1:0] vals[$];
    bit ok, seen;
    for (int i = 0; i < 2*N; i++) vals.push_back({$urandom, $urandom} | 64'h100);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wq.delete(); max_run = 0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hAA;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_valid_ready got=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    drive(vals, 0, -1, ok);
    wait_finish(seen);
    checks++;
    if (!ok || !seen || wq.size() != NC) begin
      failures++;
      $display("FAIL start_valid_flow accepted=%b finish=%b writes=%0d required 1 1 %0d",
               ok, seen, wq.size(), NC);
    end
    for (int r = 0; r < NC; r++) begin
      logic [AW+RW-1:0] exp_e, got_e;
      exp_e = {AW'(r), pack_row(vals, r)};
      got_e = (wq.size() > r) ? wq[r] : 'x;
      checks++;
      if (got_e !== exp_e) begin
        failures++;
        $display("FAIL start_valid_row%0d got=%h required=%h", r, got_e, exp_e);
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      logic [W-1:0] vals[$];
      bit ok, seen;
      for (int i = 0; i < 2*N; i++) vals.push_back({$urandom, $urandom});
      wq.delete(); max_run = 0;
      do_start();
      drive(vals, 2, -1, ok);
      wait_finish(seen);
      checks++;
      if (!ok || !seen || wq.size() != NC || max_run != 1) begin
        failures++;
        $display("FAIL random%0d_flow accepted=%b finish=%b writes=%0d pulse=%0d required 1 1 %0d 1",
                 p, ok, seen, wq.size(), max_run, NC);
      end
      for (int r = 0; r < NC; r++) begin
        logic [AW+RW-1:0] exp_e, got_e;
        exp_e = {AW'(r), pack_row(vals, r)};
        got_e = (wq.size() > r) ? wq[r] : 'x;
        checks++;
        if (got_e !== exp_e) begin
          failures++;
          $display("FAIL random%0d_row%0d got=%h required=%h", p, r, got_e, exp_e);
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_start_busy();
    test_restart();
    test_reset_mid_row();
    test_start_valid_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
